romulus_tbc_sequencer: RTL and testbench

ROMULUS_TBC_SEQUENCER -- requirements
Module: romulus_tbc_sequencer

---
 rtl/romulus_tbc_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_romulus_tbc_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/romulus_tbc_sequencer.sv
// Control sequencer for a Romulus TBC datapath: LOAD, optional ABSORB, ROUNDS rounds, CORRECT, DONE.
// Define ROMULUS_DEC_EN to honour the dec request during ABSORB; otherwise decrypt stays 16'h0000.
module romulus_tbc_sequencer #(
    parameter int unsigned ROUNDS        = 40,
    parameter int unsigned CONSTANTWIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     new_key,
    input  logic                     new_msg,
    input  logic                     absorb,
    input  logic                     dec,
    output logic                     ready,
    output logic                     pdo_valid,
    output logic                     done,
    output logic                     srst,
    output logic                     senc,
    output logic                     sen,
    output logic                     xrst,
    output logic                     xenc,
    output logic                     xen,
    output logic                     yrst,
    output logic                     yenc,
    output logic                     yen,
    output logic                     zrst,
    output logic                     zenc,
    output logic                     zen,
    output logic                     correct_cnt,
    output logic                     tk1s,
    output logic                     erst,
    output logic [15:0]              decrypt,
    output logic [CONSTANTWIDTH-1:0] constant
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned RC_W  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ABSORB,
        S_ROUND,
        S_CORRECT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic nk;
        logic nm;
        logic ab;
    } flags_t;

    typedef struct packed {
        logic            ready;
        logic            pdo_valid;
        logic            done;
        logic            srst;
        logic            senc;
        logic            sen;
        logic            xrst;
        logic            xenc;
        logic            xen;
        logic            yrst;
        logic            yenc;
        logic            yen;
        logic            zrst;
        logic            zenc;
        logic            zen;
        logic            correct_cnt;
        logic            tk1s;
        logic [15:0]     decrypt;
        logic [RC_W-1:0] rc;
    } ctrl_t;

    state_t          state_q, state_n;
    logic [RC_W-1:0] rc_q, rc_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    flags_t          flags_q, flags_n;
    ctrl_t           ctrl_q, ctrl_n;
    logic            rst_d_q;

`ifdef ROMULUS_DEC_EN
    logic dc_q, dc_n;
`else
    logic unused_dec;
    assign unused_dec = dec;
`endif

    // State, counters, latched request flags and registered control word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rc_q        <= '0;
            cnt_q       <= '0;
            flags_q     <= '0;
            rst_d_q     <= 1'b1;
            ctrl_q      <= '0;
            ctrl_q.srst <= 1'b1;
`ifdef ROMULUS_DEC_EN
            dc_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            rc_q    <= rc_n;
            cnt_q   <= cnt_n;
            flags_q <= flags_n;
            rst_d_q <= 1'b0;
            ctrl_q  <= ctrl_n;
`ifdef ROMULUS_DEC_EN
            dc_q    <= dc_n;
`endif
        end
    end

    // Next state, then controls decoded from the state being entered so they register in step with it
    always_comb begin
        state_n = state_q;
        rc_n    = rc_q;
        cnt_n   = cnt_q;
        flags_n = flags_q;
        ctrl_n  = '0;
`ifdef ROMULUS_DEC_EN
        dc_n    = dc_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && ctrl_q.ready) begin
                    state_n    = S_LOAD;
                    flags_n.nk = new_key;
                    flags_n.nm = new_msg;
                    flags_n.ab = absorb;
`ifdef ROMULUS_DEC_EN
                    dc_n       = dec;
`endif
                end
            end
            S_LOAD: begin
                rc_n    = RC_W'(6'h01);
                cnt_n   = '0;
                state_n = flags_q.ab ? S_ABSORB : S_ROUND;
            end
            S_ABSORB: state_n = S_ROUND;
            S_ROUND: begin
                rc_n = {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
                if (cnt_q == CNT_W'(ROUNDS - 1)) begin
                    cnt_n   = '0;
                    state_n = S_CORRECT;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_CORRECT: state_n = S_DONE;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase

        ctrl_n.srst = rst_d_q;
        case (state_n)
            S_IDLE: ctrl_n.ready = ~rst_d_q;
            S_LOAD: begin
                ctrl_n.xrst = flags_n.nk;
                ctrl_n.yrst = 1'b1;
                ctrl_n.zrst = flags_n.nm;
            end
            S_ABSORB: begin
                ctrl_n.sen       = 1'b1;
                ctrl_n.pdo_valid = 1'b1;
`ifdef ROMULUS_DEC_EN
                ctrl_n.decrypt   = dc_n ? 16'hFFFF : 16'h0000;
`endif
            end
            S_ROUND: begin
                ctrl_n.sen  = 1'b1;
                ctrl_n.senc = 1'b1;
                ctrl_n.xen  = 1'b1;
                ctrl_n.xenc = 1'b1;
                ctrl_n.yen  = 1'b1;
                ctrl_n.yenc = 1'b1;
                ctrl_n.zen  = 1'b1;
                ctrl_n.zenc = 1'b1;
                ctrl_n.rc   = rc_n;
            end
            S_CORRECT: begin
                ctrl_n.xen         = 1'b1;
                ctrl_n.yen         = 1'b1;
                ctrl_n.zen         = 1'b1;
                ctrl_n.correct_cnt = 1'b1;
                ctrl_n.tk1s        = 1'b1;
            end
            S_DONE:  ctrl_n.done = 1'b1;
            default: ctrl_n.done = 1'b0;
        endcase
    end

    assign ready       = ctrl_q.ready;
    assign pdo_valid   = ctrl_q.pdo_valid;
    assign done        = ctrl_q.done;
    assign srst        = ctrl_q.srst;
    assign senc        = ctrl_q.senc;
    assign sen         = ctrl_q.sen;
    assign xrst        = ctrl_q.xrst;
    assign xenc        = ctrl_q.xenc;
    assign xen         = ctrl_q.xen;
    assign yrst        = ctrl_q.yrst;
    assign yenc        = ctrl_q.yenc;
    assign yen         = ctrl_q.yen;
    assign zrst        = ctrl_q.zrst;
    assign zenc        = ctrl_q.zenc;
    assign zen         = ctrl_q.zen;
    assign correct_cnt = ctrl_q.correct_cnt;
    assign tk1s        = ctrl_q.tk1s;
    assign erst        = 1'b0;
    assign decrypt     = ctrl_q.decrypt;
    assign constant    = CONSTANTWIDTH'(ctrl_q.rc);

endmodule

// File: tb/tb_romulus_tbc_sequencer.sv
// Scoreboard bench for romulus_tbc_sequencer: driver queues expected calls, negedge monitor checks them at done.
module tb_romulus_tbc_sequencer;

    localparam int ROUNDS = 40;
    localparam int CW     = 12;

    logic clk, rst, start, new_key, new_msg, absorb, dec;
    logic ready, pdo_valid, done, srst, senc, sen, xrst, xenc, xen;
    logic yrst, yenc, yen, zrst, zenc, zen, correct_cnt, tk1s, erst;
    logic [15:0]   decrypt;
    logic [CW-1:0] constant;

    romulus_tbc_sequencer #(.ROUNDS(ROUNDS), .CONSTANTWIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .new_key(new_key), .new_msg(new_msg),
        .absorb(absorb), .dec(dec), .ready(ready), .pdo_valid(pdo_valid), .done(done),
        .srst(srst), .senc(senc), .sen(sen), .xrst(xrst), .xenc(xenc), .xen(xen),
        .yrst(yrst), .yenc(yenc), .yen(yen), .zrst(zrst), .zenc(zenc), .zen(zen),
        .correct_cnt(correct_cnt), .tk1s(tk1s), .erst(erst), .decrypt(decrypt),
        .constant(constant)
    );

    typedef struct {
        bit          nk;
        bit          nm;
        bit          ab;
        logic [15:0] dec_exp;
        int          lat;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_count = 0;
    int         done_cyc[$];
    logic [5:0] rc_model[ROUNDS];
    logic [5:0] last_rc[ROUNDS];

    bit          inflight = 0;
    int          t_acc, nrounds, nabs, ncorr, stray;
    logic        ld_x, ld_z;
    logic [15:0] abs_dec;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: collect one call's observations from LOAD to done, then score against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (rst || srst) begin
            inflight = 0;
        end else begin
            if (yrst) begin
                if (inflight) chk("overlapping_load", 32'(1), 32'(0));
                inflight = 1;
                t_acc    = cyc - 1;
                ld_x     = xrst;
                ld_z     = zrst;
                nrounds  = 0;
                nabs     = 0;
                ncorr    = 0;
                stray    = 0;
                abs_dec  = '0;
            end else if (inflight) begin
                if (sen && senc && xen && xenc && yen && yenc && zen && zenc) begin
                    if (nrounds < ROUNDS) begin
                        chk("round_constant", 32'(constant), 32'(rc_model[nrounds]));
                        last_rc[nrounds] = constant[5:0];
                    end
                    nrounds++;
                end else if (constant != '0) begin
                    stray++;
                end
                if (sen && !senc && pdo_valid) begin
                    nabs++;
                    abs_dec = decrypt;
                end
                if (correct_cnt && tk1s && xen && yen && zen && !xenc && !yenc && !zenc && !sen)
                    ncorr++;
                if (erst || xrst || zrst) stray++;
            end
            if (done) begin
                done_count++;
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", 32'(cyc - t_acc), 32'(e.lat));
                    chk("load_xrst", 32'(ld_x), 32'(e.nk));
                    chk("load_zrst", 32'(ld_z), 32'(e.nm));
                    chk("round_count", 32'(nrounds), 32'(ROUNDS));
                    chk("absorb_cycles", 32'(nabs), 32'(e.ab));
                    if (e.ab) chk("absorb_decrypt", 32'(abs_dec), 32'(e.dec_exp));
                    chk("correct_cycles", 32'(ncorr), 32'(1));
                    chk("stray_controls", 32'(stray), 32'(0));
                end
                inflight = 0;
            end
        end
    end

    function automatic logic [31:0] ctl_vec();
        return 32'({pdo_valid, done, senc, sen, xrst, xenc, xen, yrst, yenc, yen,
                    zrst, zenc, zen, correct_cnt, tk1s, erst, (decrypt != 16'h0), (constant != '0)});
    endfunction

    // Called at the negedge where rst has just been raised; holds it for hold cycles
    task automatic reset_seq(input int hold);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_srst", 32'(srst), 32'(1));
        chk("rst_ready", 32'(ready), 32'(0));
        chk("rst_controls", ctl_vec(), 32'(0));
        repeat (hold - 1) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_srst", 32'(srst), 32'(1));
        chk("post_rst_ready", 32'(ready), 32'(0));
        @(negedge clk);
        chk("idle_srst", 32'(srst), 32'(0));
        chk("idle_ready", 32'(ready), 32'(1));
        chk("idle_controls", ctl_vec(), 32'(0));
    endtask

    task automatic issue(input bit nk, input bit nm, input bit ab, input bit dc);
        exp_t e;
        int   g = 0;
        while (ready !== 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            chk("ready_timeout", 32'(0), 32'(1));
            return;
        end
        start   = 1'b1;
        new_key = nk;
        new_msg = nm;
        absorb  = ab;
        dec     = dc;
        e.nk  = nk;
        e.nm  = nm;
        e.ab  = ab;
`ifdef ROMULUS_DEC_EN
        e.dec_exp = dc ? 16'hFFFF : 16'h0000;
`else
        e.dec_exp = 16'h0000;
`endif
        e.lat = ROUNDS + 3 + int'(ab);
        exp_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        new_key = 1'($urandom);
        new_msg = 1'($urandom);
        absorb  = 1'($urandom);
        dec     = 1'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || ready !== 1'b1) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("drain_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        logic [5:0] r;
        logic [5:0] first8[8];
        int         dc0;
        first8 = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};
        r = 6'h01;
        for (int i = 0; i < ROUNDS; i++) begin
            rc_model[i] = r;
            r = {r[4:0], ~(r[5] ^ r[4])};
        end
        start = 1'b0; new_key = 1'b0; new_msg = 1'b0; absorb = 1'b0; dec = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        reset_seq(2);

        // Plain call with fresh key and message; explicit constant sequence check
        issue(1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 8; i++) chk("rc_first8", 32'(last_rc[i]), 32'(first8[i]));
        chk("rc_last", 32'(last_rc[ROUNDS-1]), 32'(6'h1A));

        // Absorb in decrypt mode
        issue(1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // Start pulsed during ROUND cycle 10 must be ignored
        dc0 = done_count;
        issue(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (50) @(negedge clk);
        chk("single_done", 32'(done_count - dc0), 32'(1));

        // Reset in the middle of ROUND cycle 20, then a normal call
        issue(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("mid_round_active", 32'(sen & senc), 32'(1));
        reset_seq(1);
        issue(1'b0, 1'b1, 1'b1, 1'b0);
        drain();

        // Back-to-back calls: second done exactly ROUNDS+4 after the first
        issue(1'b1, 1'b1, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        if (done_cyc.size() >= 2)
            chk("b2b_gap", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'(ROUNDS + 4));
        else
            chk("b2b_done_count", 32'(done_cyc.size()), 32'(2));

        // Randomized calls with random idle gaps
        for (int n = 0; n < 14; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();
        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
